// File: rtl/multiword_add_seq.sv
// Wide adder that reuses one N-bit slice adder across WORDS cycles, LSB slice first.
// Define MULTIWORD_ADD_SUB_EN to enable subtraction through the sub input.

module nbit_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

endmodule

module multiword_add_seq #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   input  logic                 cin,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   sum,
   output logic                 cout,
   output logic                 busy
);

   localparam int W  = N * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    result;
   logic [W-1:0]    result_next;
   logic            carry;
   logic [IW-1:0]   idx;
   logic            last;
   logic [N-1:0]    a_slice;
   logic [N-1:0]    b_slice;
   logic [N-1:0]    slice_sum;
   logic            slice_carry;
   logic [W-1:0]    b_load;
   logic            carry_load;

   // Subtraction is a + ~b + 1, so only the B load and the initial carry change.
`ifdef MULTIWORD_ADD_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_load     = b;
   assign carry_load = cin;
`endif

   assign last = (idx == IW'(WORDS - 1));

   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx == IW'(i)) begin
            a_slice = a_reg[i*N +: N];
            b_slice = b_reg[i*N +: N];
         end
      end
   end

   nbit_adder #(.N(N)) u_adder (
      .a  (a_slice),
      .b  (b_slice),
      .ci (carry),
      .s  (slice_sum),
      .co (slice_carry)
   );

   always_comb begin
      result_next = result;
      for (int i = 0; i < WORDS; i++) begin
         if (idx == IW'(i)) begin
            result_next[i*N +: N] = slice_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid)  state_next = RUN;
         RUN:  if (last)      state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default:             state_next = IDLE;
      endcase
   end

   // idx parks on the last slice in DONE; the next accept rewinds it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg  <= '0;
         b_reg  <= '0;
         result <= '0;
         carry  <= 1'b0;
         idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg  <= a;
                  b_reg  <= b_load;
                  carry  <= carry_load;
                  idx    <= '0;
                  result <= '0;
               end
            end
            RUN: begin
               result <= result_next;
               carry  <= slice_carry;
               if (!last) begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = result;
   assign cout      = carry;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: a 4x4-bit instance plus a 1x8-bit instance,
// compared against plain-arithmetic models of a wide add (or subtract when MULTIWORD_ADD_SUB_EN).

module tb_multiword_add_seq;

`ifdef MULTIWORD_ADD_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, busy;
   logic [15:0] opa, opb, sum;

   logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_busy;
   logic [7:0]  w_a, w_b, w_sum;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multiword_add_seq #(.N(4), .WORDS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(opa), .b(opb), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
   );

   multiword_add_seq #(.N(8), .WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
      .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .busy(w_busy)
   );

   function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y,
                                           input logic c, input logic s);
      int unsigned r;
      if (SUB_EN && s) r = int'(x) - int'(y) + 65536;
      else             r = int'(x) + int'(y) + int'(c);
      return r[16:0];
   endfunction

   function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
      int unsigned r;
      if (SUB_EN && s) r = int'(x) - int'(y) + 256;
      else             r = int'(x) + int'(y) + int'(c);
      return r[8:0];
   endfunction

   task step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic ts, input int hold, output logic [15:0] rs,
                         output logic rc, output int lat, output int ready_bad);
      ready_bad = 0;
      opa = ta; opb = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      opa = 16'($urandom); opb = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (in_ready !== 1'b0) ready_bad++;
         step;
         lat++;
      end
      for (int i = 0; i < hold; i++) step;
      rs = sum;
      rc = cout;
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
   endtask

   task test_reset;
      rst_n = 1'b0;
      in_valid = 0; out_ready = 0; cin = 0; sub = 0; opa = 0; opb = 0;
      w_in_valid = 0; w_out_ready = 0; w_cin = 0; w_sub = 0; w_a = 0; w_b = 0;
      #2;
      checks++;
      if ({in_ready, out_valid, busy, cout} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b exp 1000", {in_ready, out_valid, busy, cout});
      end
      checks++;
      if (sum !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_sum got %h exp 0000", sum);
      end
      checks++;
      if ({w_in_ready, w_out_valid, w_busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL reset_w1_flags got %b exp 100", {w_in_ready, w_out_valid, w_busy});
      end
      step;
      step;
      rst_n = 1'b1;
      step;
   endtask

   task test_add_basic;
      logic [15:0] rs;
      logic        rc;
      int          lat, rb;
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, rs, rc, lat, rb);
      checks++;
      if (rs !== 16'h2345 || rc !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_add got %b_%h exp 0_2345", rc, rs);
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("[TB] FAIL basic_latency got %0d exp 4", lat);
      end
      checks++;
      if (rb !== 0) begin
         errors++;
         $display("[TB] FAIL basic_in_ready_busy got %0d high cycles exp 0", rb);
      end
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL basic_return_idle got %b exp 100", {in_ready, out_valid, busy});
      end
   endtask

   task test_ripple;
      logic [15:0] rs;
      logic        rc;
      int          lat, rb;
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, lat, rb);
      checks++;
      if (rs !== 16'h0000 || rc !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ripple_full got %b_%h exp 1_0000", rc, rs);
      end
      run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 1, rs, rc, lat, rb);
      checks++;
      if (rs !== 16'h0100 || rc !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ripple_cin got %b_%h exp 0_0100", rc, rs);
      end
   endtask

   task test_backpressure;
      logic [15:0] hs;
      logic        hc;
      logic [16:0] exp;
      int          lat;
      opa = 16'hABCD; opb = 16'h1357; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin step; lat++; end
      hs = sum;
      hc = cout;
      checks++;
      if ({hc, hs} !== 17'h0BF25) begin
         errors++;
         $display("[TB] FAIL bp_first got %b_%h exp 0_bf25", hc, hs);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         opa = 16'($urandom); opb = 16'($urandom); cin = 1'($urandom);
         step;
         checks++;
         if (sum !== hs || cout !== hc || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cycle %0d got %b_%h v%b r%b exp %b_%h v1 r0",
                     i, cout, sum, out_valid, in_ready, hc, hs);
         end
      end
      opa = 16'h4321; opb = 16'h0F0F; cin = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      step;
      out_ready = 1'b0;
      checks++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL bp_not_taken got %b exp 100", {in_ready, busy, out_valid});
      end
      step;
      in_valid = 1'b0;
      exp = model16(16'h4321, 16'h0F0F, 1'b0, 1'b0);
      lat = 0;
      while (!out_valid && lat < 20) begin step; lat++; end
      checks++;
      if ({cout, sum} !== exp || lat !== 4) begin
         errors++;
         $display("[TB] FAIL bp_next got %b_%h lat %0d exp %b_%h lat 4",
                  cout, sum, lat, exp[16], exp[15:0]);
      end
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
   endtask

   task test_reset_mid_run;
      logic [15:0] rs;
      logic        rc;
      int          lat, rb;
      opa = 16'hFFFF; opb = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step;
      step;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, in_ready, cout} !== 4'b0010 || sum !== 16'h0) begin
         errors++;
         $display("[TB] FAIL midrun_reset got v%b b%b r%b c%b sum %h exp v0 b0 r1 c0 sum 0000",
                  out_valid, busy, in_ready, cout, sum);
      end
      step;
      rst_n = 1'b1;
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, rs, rc, lat, rb);
      checks++;
      if (rs !== 16'h0003 || rc !== 1'b0 || lat !== 4) begin
         errors++;
         $display("[TB] FAIL midrun_after got %b_%h lat %0d exp 0_0003 lat 4", rc, rs, lat);
      end
   endtask

   task test_sub;
      logic [15:0] rs;
      logic        rc;
      int          lat, rb;
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, rs, rc, lat, rb);
      checks++;
      if (SUB_EN ? ({rc, rs} !== 17'h0FFFE) : ({rc, rs} !== 17'h0000C)) begin
         errors++;
         $display("[TB] FAIL sub_5_7 got %b_%h exp %s", rc, rs, SUB_EN ? "0_fffe" : "0_000c");
      end
      run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, rs, rc, lat, rb);
      checks++;
      if (SUB_EN ? ({rc, rs} !== 17'h10002) : ({rc, rs} !== 17'h0000C)) begin
         errors++;
         $display("[TB] FAIL sub_7_5 got %b_%h exp %s", rc, rs, SUB_EN ? "1_0002" : "0_000c");
      end
   endtask

   task test_random;
      logic [15:0] ta, tbv, rs;
      logic        tc, ts, rc;
      logic [16:0] exp;
      int          lat, rb;
      for (int i = 0; i < 25; i++) begin
         ta = 16'($urandom); tbv = 16'($urandom);
         tc = 1'($urandom);  ts = 1'($urandom);
         exp = model16(ta, tbv, tc, ts);
         run_op(ta, tbv, tc, ts, int'($urandom_range(0, 2)), rs, rc, lat, rb);
         checks++;
         if ({rc, rs} !== exp || lat !== 4 || rb !== 0) begin
            errors++;
            $display("[TB] FAIL random %0d a %h b %h c %b s %b got %b_%h lat %0d exp %b_%h lat 4",
                     i, ta, tbv, tc, ts, rc, rs, lat, exp[16], exp[15:0]);
         end
      end
   endtask

   task test_words1;
      logic [8:0] exp;
      int         lat;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            w_a = 8'hF0; w_b = 8'h20; w_cin = 1'b1; w_sub = 1'b0;
         end else begin
            w_a = 8'($urandom); w_b = 8'($urandom); w_cin = 1'($urandom); w_sub = 1'($urandom);
         end
         exp = model8(w_a, w_b, w_cin, w_sub);
         w_in_valid = 1'b1;
         step;
         w_in_valid = 1'b0;
         lat = 0;
         while (!w_out_valid && lat < 20) begin step; lat++; end
         checks++;
         if ({w_cout, w_sum} !== exp || lat !== 1) begin
            errors++;
            $display("[TB] FAIL words1 %0d got %b_%h lat %0d exp %b_%h lat 1",
                     i, w_cout, w_sum, lat, exp[8], exp[7:0]);
         end
         w_out_ready = 1'b1;
         step;
         w_out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset;
      test_add_basic;
      test_ripple;
      test_backpressure;
      test_reset_mid_run;
      test_sub;
      test_random;
      test_words1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
